// File: rtl/execute_stage.sv
// execute_stage: execute stage of the MyMIPS five-stage pipeline.
//   Single-cycle ALU / address generation, registered toward the memory stage,
//   plus an iterative 32-step multiply/divide unit writing HI/LO.
// Ports:
//   Clk, Reset_n                 clock (rising edge), async active-low reset
//   Op1, Op2, Dst, SA, StoreVal  operands from decode
//   Control                      [31] writeback, [30:0] OP_* flags
//   Result, DstOut, StoreValOut  registered results toward memory stage
//   ControlOut                   registered control (writeback dropped on ovf/MD)
//   RdEx                         one-hot mask of the register produced this cycle
//   Hi, Lo                       multiply/divide result registers
//   Busy                         multiply/divide in flight; upstream stalls
//   Overflow                     one-cycle signed add/sub overflow pulse
module execute_stage #(
    parameter int XLEN     = 32,
    parameter int MD_STEPS = 32
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic [XLEN-1:0] Op1,
    input  logic [XLEN-1:0] Op2,
    input  logic [4:0]      Dst,
    input  logic [4:0]      SA,
    input  logic [XLEN-1:0] StoreVal,
    input  logic [31:0]     Control,
    output logic [XLEN-1:0] Result,
    output logic [4:0]      DstOut,
    output logic [XLEN-1:0] StoreValOut,
    output logic [31:0]     ControlOut,
    output logic [31:0]     RdEx,
    output logic [XLEN-1:0] Hi,
    output logic [XLEN-1:0] Lo,
    output logic            Busy,
    output logic            Overflow
);
    // OP_* flag positions within Control
    localparam int OP_ADD      = 0;
    localparam int OP_SUB      = 1;
    localparam int OP_AND      = 2;
    localparam int OP_OR       = 3;
    localparam int OP_XOR      = 4;
    localparam int OP_NOR      = 5;
    localparam int OP_SHIFTL   = 6;
    localparam int OP_SHIFTR   = 7;
    localparam int OP_SHFAR    = 8;
    localparam int OP_LOAD     = 9;
    localparam int OP_STORE    = 10;
    localparam int OP_MULT     = 11;
    localparam int OP_DIV      = 12;
    localparam int OP_UNSIGNED = 13;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;

    localparam int CNT_W = $clog2(MD_STEPS + 1);

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [2*XLEN-1:0] acc;     // MUL: {partial, multiplier}; DIV: {remainder, dividend/quotient}
    logic [XLEN-1:0]   md_b;    // multiplicand or divisor magnitude
    logic              neg_q;   // negate product / quotient
    logic              neg_r;   // negate remainder

    // ---------------- single-cycle ALU ----------------
    logic            uns;
    logic [XLEN-1:0] sum, diff, alu_res;
    logic            alu_ovf;

    assign uns  = Control[OP_UNSIGNED];
    assign sum  = Op1 + Op2;
    assign diff = Op1 - Op2;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        if (Control[OP_ADD]) begin
            alu_res = sum;
            alu_ovf = !uns && (Op1[XLEN-1] == Op2[XLEN-1]) && (sum[XLEN-1] != Op1[XLEN-1]);
        end else if (Control[OP_SUB]) begin
            alu_res = diff;
            alu_ovf = !uns && (Op1[XLEN-1] != Op2[XLEN-1]) && (diff[XLEN-1] != Op1[XLEN-1]);
        end else if (Control[OP_AND]) alu_res = Op1 & Op2;
        else if (Control[OP_OR])      alu_res = Op1 | Op2;
        else if (Control[OP_XOR])     alu_res = Op1 ^ Op2;
        else if (Control[OP_NOR])     alu_res = ~(Op1 | Op2);
        else if (Control[OP_SHIFTL])  alu_res = Op2 << SA;
        else if (Control[OP_SHIFTR]) begin
            // kept as if/else: a ternary would make the arithmetic shift unsigned
            if (Control[OP_SHFAR]) alu_res = $signed(Op2) >>> SA;
            else                   alu_res = Op2 >> SA;
        end else if (Control[OP_LOAD] || Control[OP_STORE]) alu_res = sum;
    end

    // ---------------- multiply/divide ----------------
    logic            md_req, is_mul, div0;
    logic [XLEN-1:0] mag1, mag2;

    assign is_mul = Control[OP_MULT];
    assign md_req = !Busy && (Control[OP_MULT] || Control[OP_DIV]);
    assign div0   = !is_mul && (Op2 == '0);
    // -0x8000_0000 wraps to 0x8000_0000, which is exactly the unsigned magnitude
    assign mag1   = (!uns && Op1[XLEN-1]) ? -Op1 : Op1;
    assign mag2   = (!uns && Op2[XLEN-1]) ? -Op2 : Op2;

    logic [XLEN:0]     mul_sum, div_t, div_d;
    logic [2*XLEN-1:0] mul_next, div_next, prod;
    logic [XLEN-1:0]   quo, rem;

    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, md_b} : '0);
        mul_next = {mul_sum, acc[XLEN-1:1]};
        div_t    = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_d    = div_t - {1'b0, md_b};
        div_next = div_d[XLEN] ? {div_t[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                               : {div_d[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        prod     = neg_q ? -mul_next : mul_next;
        quo      = neg_q ? -div_next[XLEN-1:0] : div_next[XLEN-1:0];
        rem      = neg_r ? -div_next[2*XLEN-1:XLEN] : div_next[2*XLEN-1:XLEN];
    end

    assign Busy = (state != S_IDLE);
    assign RdEx = (ControlOut[31] && DstOut != 5'd0) ? (32'd1 << DstOut) : 32'd0;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            acc         <= '0;
            md_b        <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            Result      <= '0;
            DstOut      <= '0;
            StoreValOut <= '0;
            ControlOut  <= '0;
            Hi          <= '0;
            Lo          <= '0;
            Overflow    <= 1'b0;
        end else begin
            Overflow <= 1'b0;
            if (Busy) begin
                // stalled: pipeline inputs ignored, outputs other than HI/LO hold
                ControlOut <= '0;
                cnt        <= cnt - CNT_W'(1);
                acc        <= (state == S_MUL) ? mul_next : div_next;
                if (cnt == CNT_W'(1)) begin
                    state <= S_IDLE;
                    if (state == S_MUL) begin
                        Hi <= prod[2*XLEN-1:XLEN];
                        Lo <= prod[XLEN-1:0];
                    end else begin
                        Hi <= rem;
                        Lo <= quo;
                    end
                end
            end else begin
                DstOut      <= Dst;
                StoreValOut <= StoreVal;
                if (md_req) begin
                    Result     <= '0;
                    ControlOut <= '0;
                    if (div0) begin
                        Lo <= '1;
                        Hi <= Op1;
                    end else begin
                        state <= is_mul ? S_MUL : S_DIV;
                        cnt   <= CNT_W'(MD_STEPS);
                        acc   <= {{XLEN{1'b0}}, is_mul ? mag2 : mag1};
                        md_b  <= is_mul ? mag1 : mag2;
                        neg_q <= !uns && (Op1[XLEN-1] ^ Op2[XLEN-1]);
                        neg_r <= !uns && Op1[XLEN-1];
                    end
                end else if (Control[30:0] == 31'd0) begin
                    Result     <= '0;
                    ControlOut <= '0;
                end else begin
                    Result     <= alu_res;
                    Overflow   <= alu_ovf;
                    ControlOut <= {Control[31] & ~alu_ovf, Control[30:0]};
                end
            end
        end
    end
endmodule
